// File: rtl/rr_arb2_stage_if.sv
// Handshake bundle for the two-input round-robin arbiter stage.
// The master side drives the requests and the consumer ready; the slave side is the arbiter.
interface rr_arb2_stage_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 8
);
    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_valid;
    logic                  a_ready;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  b_valid;
    logic                  b_ready;
    logic                  sel;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_src;
    logic [CNT_WIDTH-1:0]  a_cnt;
    logic [CNT_WIDTH-1:0]  b_cnt;

    modport master (
        output a_data, a_valid, b_data, b_valid, out_ready,
        input  a_ready, b_ready, sel, out_data, out_valid, out_src, a_cnt, b_cnt
    );

    modport slave (
        input  a_data, a_valid, b_data, b_valid, out_ready,
        output a_ready, b_ready, sel, out_data, out_valid, out_src, a_cnt, b_cnt
    );
endinterface

// File: rtl/rr_arb2_stage.sv
// Two-input round-robin arbiter feeding a single registered output slot, with
// per-input acceptance counters.
module rr_arb2_stage #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input logic               clk,
    input logic               rst_n,
    rr_arb2_stage_if.slave    bus
);
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  out_src_q;
    logic                  prio_a_q;
    logic [CNT_WIDTH-1:0]  a_cnt_q;
    logic [CNT_WIDTH-1:0]  b_cnt_q;

    logic load;
    logic gnt_a;
    logic gnt_b;

    // Grants are masked by rst_n so no ready is shown while reset is held.
    assign load  = !out_valid_q || bus.out_ready;
    assign gnt_a = rst_n && load && bus.a_valid && (prio_a_q || !bus.b_valid);
    assign gnt_b = rst_n && load && bus.b_valid && !gnt_a;

    assign bus.a_ready   = gnt_a;
    assign bus.b_ready   = gnt_b;
    assign bus.sel       = (gnt_a || gnt_b) ? gnt_a : prio_a_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_src   = out_src_q;
    assign bus.a_cnt     = a_cnt_q;
    assign bus.b_cnt     = b_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= 1'b0;
            prio_a_q    <= 1'b1;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
        end else if (gnt_a) begin
            out_data_q  <= bus.a_data;
            out_valid_q <= 1'b1;
            out_src_q   <= 1'b1;
            prio_a_q    <= 1'b0;
            a_cnt_q     <= a_cnt_q + 1'b1;
        end else if (gnt_b) begin
            out_data_q  <= bus.b_data;
            out_valid_q <= 1'b1;
            out_src_q   <= 1'b0;
            prio_a_q    <= 1'b1;
            b_cnt_q     <= b_cnt_q + 1'b1;
        end else if (load) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_arb2_stage.sv
// Directed bench for rr_arb2_stage: a vector table plus hand-written sequences
// for reset, counter wrap and asynchronous reset.
module tb_rr_arb2_stage;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rr_arb2_stage_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    rr_arb2_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          av;
        logic          bv;
        logic [DW-1:0] ad;
        logic [DW-1:0] bd;
        logic          ordy;
        logic          ar;
        logic          br;
        logic          sel;
        logic          ov;
        logic [DW-1:0] od;
        logic          src;
        logic [CW-1:0] ac;
        logic [CW-1:0] bc;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic bv, input logic [DW-1:0] ad,
                         input logic [DW-1:0] bd, input logic ordy);
        bus.a_valid   = av;
        bus.b_valid   = bv;
        bus.a_data    = ad;
        bus.b_data    = bd;
        bus.out_ready = ordy;
    endtask

    // Reset and release, ending at posedge+1.
    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        drive(1'b1, 1'b1, 16'h5555, 16'h6666, 1'b1);
        #2;
        check("rst_a_ready", 32'(bus.a_ready), 32'h0);
        check("rst_b_ready", 32'(bus.b_ready), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data", 32'(bus.out_data), 32'h0);
        check("rst_out_src", 32'(bus.out_src), 32'h0);
        check("rst_sel", 32'(bus.sel), 32'h1);
        check("rst_a_cnt", 32'(bus.a_cnt), 32'h0);
        check("rst_b_cnt", 32'(bus.b_cnt), 32'h0);
        @(posedge clk);
        #1;
        check("rst_held_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_held_a_cnt", 32'(bus.a_cnt), 32'h0);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);

        //           av  bv  ad        bd        or   ar  br  sel ov  od        src ac  bc
        vecs[0]  = '{1, 1, 16'h0001, 16'h1001, 1, 1, 0, 1, 1, 16'h0001, 1, 8'd1, 8'd0};
        vecs[1]  = '{1, 1, 16'h0002, 16'h1001, 1, 0, 1, 0, 1, 16'h1001, 0, 8'd1, 8'd1};
        vecs[2]  = '{1, 1, 16'h0002, 16'h1002, 1, 1, 0, 1, 1, 16'h0002, 1, 8'd2, 8'd1};
        vecs[3]  = '{1, 1, 16'h0003, 16'h1002, 1, 0, 1, 0, 1, 16'h1002, 0, 8'd2, 8'd2};
        vecs[4]  = '{0, 1, 16'h0000, 16'hBEEF, 1, 0, 1, 0, 1, 16'hBEEF, 0, 8'd2, 8'd3};
        vecs[5]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 0, 16'hBEEF, 0, 8'd2, 8'd3};
        vecs[6]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 0, 16'hBEEF, 0, 8'd2, 8'd3};
        vecs[7]  = '{1, 0, 16'h0A0A, 16'h0000, 0, 1, 0, 1, 1, 16'h0A0A, 1, 8'd3, 8'd3};
        vecs[8]  = '{1, 1, 16'h1111, 16'h2222, 0, 0, 0, 0, 1, 16'h0A0A, 1, 8'd3, 8'd3};
        vecs[9]  = '{1, 1, 16'h1111, 16'h2222, 0, 0, 0, 0, 1, 16'h0A0A, 1, 8'd3, 8'd3};
        vecs[10] = '{1, 1, 16'h1111, 16'h2222, 0, 0, 0, 0, 1, 16'h0A0A, 1, 8'd3, 8'd3};
        vecs[11] = '{1, 1, 16'h1111, 16'h2222, 1, 0, 1, 0, 1, 16'h2222, 0, 8'd3, 8'd4};
        vecs[12] = '{1, 0, 16'h3333, 16'h2222, 1, 1, 0, 1, 1, 16'h3333, 1, 8'd4, 8'd4};

        do_reset();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].av, vecs[i].bv, vecs[i].ad, vecs[i].bd, vecs[i].ordy);
            #3;
            check($sformatf("v%0d_a_ready", i), 32'(bus.a_ready), 32'(vecs[i].ar));
            check($sformatf("v%0d_b_ready", i), 32'(bus.b_ready), 32'(vecs[i].br));
            check($sformatf("v%0d_sel", i), 32'(bus.sel), 32'(vecs[i].sel));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
            check($sformatf("v%0d_out_data", i), 32'(bus.out_data), 32'(vecs[i].od));
            check($sformatf("v%0d_out_src", i), 32'(bus.out_src), 32'(vecs[i].src));
            check($sformatf("v%0d_a_cnt", i), 32'(bus.a_cnt), 32'(vecs[i].ac));
            check($sformatf("v%0d_b_cnt", i), 32'(bus.b_cnt), 32'(vecs[i].bc));
        end

        // Counter wrap: 256 A-only transfers from a fresh reset.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, 16'(i), 16'h0000, 1'b1);
            @(posedge clk);
            #1;
            if (i == 254) check("wrap_a_cnt_255", 32'(bus.a_cnt), 32'hFF);
        end
        check("wrap_a_cnt_0", 32'(bus.a_cnt), 32'h0);
        check("wrap_b_cnt_0", 32'(bus.b_cnt), 32'h0);
        check("wrap_last_data", 32'(bus.out_data), 32'h00FF);

        // Asynchronous reset pulse between edges while a word is held.
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        check("async_pre_valid", 32'(bus.out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(bus.out_valid), 32'h0);
        check("async_out_data", 32'(bus.out_data), 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 16'hA1A1, 16'hB1B1, 1'b1);
        #3;
        check("post_rst_a_ready", 32'(bus.a_ready), 32'h1);
        check("post_rst_b_ready", 32'(bus.b_ready), 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_out_data", 32'(bus.out_data), 32'hA1A1);
        check("post_rst_out_src", 32'(bus.out_src), 32'h1);
        check("post_rst_a_cnt", 32'(bus.a_cnt), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_arb2_stage.md
RR_ARB2_STAGE -- requirements
Module: rr_arb2_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of every data bus.
REQ-002 Parameter CNT_WIDTH, default 8: width of each per-input grant counter.
REQ-003 clk  input  1  single clock; every register is updated on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low; one clock; reset is asynchronous and active-low.
REQ-005 a_data  input  DATA_WIDTH  payload of channel A.
REQ-006 a_valid  input  1  channel A offers a word.
REQ-007 a_ready  output  1  channel A word accepted this cycle.
REQ-008 b_data  input  DATA_WIDTH  payload of channel B.
REQ-009 b_valid  input  1  channel B offers a word.
REQ-010 b_ready  output  1  channel B word accepted this cycle.
REQ-011 sel  output  1  combinational select for the downstream 2:1 mux; 1 = A, 0 = B.
REQ-012 out_data  output  DATA_WIDTH  registered granted word.
REQ-013 out_valid  output  1  out_data holds a word.
REQ-014 out_ready  input  1  consumer takes out_data this cycle.
REQ-015 out_src  output  1  source of the held word; 1 = A, 0 = B.
REQ-016 a_cnt, b_cnt  output  CNT_WIDTH each  number of words accepted from A and from B.

Function
REQ-017 load = !out_valid || out_ready; the output register accepts a new word only when load is 1.
REQ-018 prio_a is an internal round-robin pointer; 1 = A has priority.
REQ-019 Grant A (gnt_a) = load & a_valid & (prio_a | !b_valid); grant B (gnt_b) = load & b_valid & !gnt_a; gnt_a and gnt_b are never both 1.
REQ-020 a_ready = gnt_a and b_ready = gnt_b, both combinational; a ready is never asserted when its own valid is 0.
REQ-021 sel = gnt_a when gnt_a | gnt_b; otherwise sel = prio_a.
REQ-022 On gnt_a: out_data <= a_data, out_src <= 1, out_valid <= 1, prio_a <= 0, a_cnt <= a_cnt+1.
REQ-023 On gnt_b: out_data <= b_data, out_src <= 0, out_valid <= 1, prio_a <= 1, b_cnt <= b_cnt+1.
REQ-024 load=1 with no valid input: out_valid <= 0; out_data, out_src, prio_a and the counters hold.
REQ-025 load=0 (out_valid=1, out_ready=0): all registers hold; a_ready = b_ready = 0; the held word stays stable until consumed.
REQ-026 Simultaneous consume and accept: out_valid=1, out_ready=1, and an input valid together give back-to-back transfers at one word per cycle with no bubble.
REQ-027 Latency: a word accepted in cycle N appears on out_data with out_valid=1 in cycle N+1.
REQ-028 Counters wrap modulo 2^CNT_WIDTH with no saturation and no flag.
REQ-029 Only a single requester is ever granted, regardless of prio_a; prio_a changes only on a grant.

Reset
REQ-030 While rst_n=0: out_valid=0, out_data=0, out_src=0, prio_a=1, a_cnt=0, b_cnt=0, a_ready=0, b_ready=0.
REQ-031 Assertion of rst_n mid-transfer discards the held word immediately, without waiting for a clock edge.
REQ-032 Input words offered in the cycle reset asserts are not counted.
REQ-033 The first grant after reset release goes to A if both inputs are valid.

Verification
REQ-034 Reset release, a_valid=b_valid=1 continuously, out_ready=1, A words 0x0001.., B words 0x1001.. -> out_data sequence 0x0001, 0x1001, 0x0002, 0x1002; out_src toggles 1,0,1,0.
REQ-035 Only b_valid=1 (0xBEEF), prio_a=1 -> b_ready=1, sel=0; next cycle out_data=0xBEEF, out_src=0, b_cnt=1.
REQ-036 Output held with out_ready=0 for 3 cycles while both inputs are valid -> a_ready=b_ready=0, out_data stable, counters unchanged; on out_ready=1 the next grant is accepted in the same cycle.
REQ-037 CNT_WIDTH=8, 256 A-only transfers -> a_cnt returns to 0x00, b_cnt=0.
REQ-038 rst_n pulsed low asynchronously between clock edges while out_valid=1 -> out_valid drops to 0 before the next edge; after release the first grant goes to A.
REQ-039 No inputs valid, out_ready=1 -> out_valid=0 and sel equals prio_a.
